// File: rtl/spi_fram_pkg.sv
// Shared definitions for the SPI FRAM master: opcodes, host command encoding,
// FSM states, per-command frame lengths and frame/bit helpers.
package spi_fram_pkg;

  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_RDSR  = 8'h05;

  typedef enum logic [1:0] {
    CMD_WREN  = 2'b00,
    CMD_WRITE = 2'b01,
    CMD_READ  = 2'b10,
    CMD_RDSR  = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCK_LO,
    ST_SCK_HI,
    ST_HOLD,
    ST_CSIDLE
  } state_e;

  localparam logic [5:0] BITS_WREN  = 6'd8;
  localparam logic [5:0] BITS_RDSR  = 6'd16;
  localparam logic [5:0] BITS_READ  = 6'd40;
  localparam logic [5:0] BITS_WRITE = 6'd40;

  // Five tx bytes, MSB-aligned; unused trailing bytes are zero (dummy clocks).
  function automatic logic [39:0] build_frame(input cmd_e cmd, input logic [23:0] addr,
                                              input logic [7:0] wdata);
    logic [39:0] f;
    case (cmd)
      CMD_WREN:  f = {OP_WREN, 32'h0};
      CMD_RDSR:  f = {OP_RDSR, 32'h0};
      CMD_READ:  f = {OP_READ, addr, 8'h00};
      default:   f = {OP_WRITE, addr, wdata};
    endcase
    return f;
  endfunction

  function automatic logic [5:0] frame_bits(input cmd_e cmd);
    logic [5:0] n;
    case (cmd)
      CMD_WREN:  n = BITS_WREN;
      CMD_RDSR:  n = BITS_RDSR;
      CMD_READ:  n = BITS_READ;
      default:   n = BITS_WRITE;
    endcase
    return n;
  endfunction

  // count[5:3] picks the tx byte, count[2:0] the bit within it (MSB first).
  function automatic logic tx_bit(input logic [39:0] frame, input logic [5:0] count);
    logic [7:0] b;
    case (count[5:3])
      3'd0:    b = frame[39:32];
      3'd1:    b = frame[31:24];
      3'd2:    b = frame[23:16];
      3'd3:    b = frame[15:8];
      3'd4:    b = frame[7:0];
      default: b = 8'h00;
    endcase
    return b[3'd7 - count[2:0]];
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// SCK phase timer: counts CLK_DIV clk cycles per SCK phase while run is high
// and strobes phase_end_c on the last cycle of each phase.
// Ports: clk, rst (async, active-high), run (frame in progress),
//        phase_end_c (combinational end-of-phase strobe).
module spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic phase_end_c
);

  logic [7:0] cnt;

  assign phase_end_c = run && (cnt == 8'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 8'd0;
    end else if (!run || phase_end_c) begin
      cnt <= 8'd0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_fram_master.sv
// SPI mode-0 master issuing FRAM byte transactions (WREN, WRITE, READ, RDSR).
// Host: req_valid/req_ready/req_cmd/req_addr/req_wdata in, rsp_valid/rsp_rdata
// out (one-cycle pulse), busy. SPI: spi_cs, spi_sck, spi_mosi out, spi_miso in.
// clk / rst: rising-edge clock, asynchronous active-high reset.
// Optional: define SPI_FRAM_AUTO_WREN_EN to precede every WRITE with an
// automatic WREN frame (one response, after the WRITE frame only).
module spi_fram_master
  import spi_fram_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned CS_IDLE    = 4,
  parameter int unsigned ADDR_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_cmd,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [7:0]            req_wdata,
  output logic                  rsp_valid,
  output logic [7:0]            rsp_rdata,
  output logic                  busy,
  output logic                  spi_cs,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned IDLE_W = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

  state_e            state;
  cmd_e              cur_cmd;
  logic [23:0]       addr_q;
  logic [7:0]        wdata_q;
  logic [7:0]        rx;
  logic [5:0]        bit_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              pend_write;

  logic        run_c;
  logic        phase_end_c;
  logic [39:0] frame_c;
  logic [5:0]  last_bit_c;
  cmd_e        first_cmd_c;
  logic        wants_pend_c;
  logic        first_bit_c;
  logic [23:0] req_addr24_c;

  assign run_c        = (state == ST_SETUP) || (state == ST_SCK_LO) ||
                        (state == ST_SCK_HI) || (state == ST_HOLD);
  assign frame_c      = build_frame(cur_cmd, addr_q, wdata_q);
  assign last_bit_c   = frame_bits(cur_cmd) - 6'd1;
  assign req_addr24_c = 24'(req_addr);

  // With auto-WREN a WRITE request opens with a WREN frame and parks the write.
`ifdef SPI_FRAM_AUTO_WREN_EN
  assign wants_pend_c = (cmd_e'(req_cmd) == CMD_WRITE);
`else
  assign wants_pend_c = 1'b0;
`endif
  assign first_cmd_c = wants_pend_c ? CMD_WREN : cmd_e'(req_cmd);
  assign first_bit_c = tx_bit(build_frame(first_cmd_c, req_addr24_c, req_wdata), 6'd0);

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk         (clk),
    .rst         (rst),
    .run         (run_c),
    .phase_end_c (phase_end_c)
  );

  // Frame sequencer with registered host and SPI outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cur_cmd    <= CMD_WREN;
      addr_q     <= 24'h0;
      wdata_q    <= 8'h00;
      rx         <= 8'h00;
      bit_cnt    <= 6'd0;
      idle_cnt   <= '0;
      pend_write <= 1'b0;
      spi_cs     <= 1'b1;
      spi_sck    <= 1'b0;
      spi_mosi   <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            cur_cmd    <= first_cmd_c;
            addr_q     <= req_addr24_c;
            wdata_q    <= req_wdata;
            pend_write <= wants_pend_c;
            bit_cnt    <= 6'd0;
            spi_cs     <= 1'b0;
            spi_mosi   <= first_bit_c;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (phase_end_c) state <= ST_SCK_LO;
        end
        ST_SCK_LO: begin
          // MISO is captured on the same edge that raises SCK.
          if (phase_end_c) begin
            spi_sck <= 1'b1;
            rx      <= {rx[6:0], spi_miso};
            state   <= ST_SCK_HI;
          end
        end
        ST_SCK_HI: begin
          if (phase_end_c) begin
            spi_sck <= 1'b0;
            if (bit_cnt == last_bit_c) begin
              spi_mosi <= 1'b0;
              state    <= ST_HOLD;
            end else begin
              bit_cnt  <= bit_cnt + 6'd1;
              spi_mosi <= tx_bit(frame_c, bit_cnt + 6'd1);
              state    <= ST_SCK_LO;
            end
          end
        end
        ST_HOLD: begin
          // CS rises only after SCK has been low for a full phase.
          if (phase_end_c) begin
            spi_cs   <= 1'b1;
            idle_cnt <= '0;
            state    <= ST_CSIDLE;
            if (!pend_write) begin
              rsp_valid <= 1'b1;
              rsp_rdata <= ((cur_cmd == CMD_READ) || (cur_cmd == CMD_RDSR)) ? rx : 8'h00;
            end
          end
        end
        ST_CSIDLE: begin
          if (idle_cnt == IDLE_W'(CS_IDLE - 1)) begin
            if (pend_write) begin
              pend_write <= 1'b0;
              cur_cmd    <= CMD_WRITE;
              bit_cnt    <= 6'd0;
              spi_cs     <= 1'b0;
              spi_mosi   <= tx_bit(build_frame(CMD_WRITE, addr_q, wdata_q), 6'd0);
              state      <= ST_SETUP;
            end else begin
              req_ready <= 1'b1;
              busy      <= 1'b0;
              state     <= ST_IDLE;
            end
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_fram_master.sv
// Bench for spi_fram_master: behavioural FRAM slave on the SPI pins, a
// transaction-level reference model for responses, and frame/CS-timing checks.
// Honours SPI_FRAM_AUTO_WREN_EN when compiled with the same define as the RTL.
module tb_spi_fram_master;

  localparam int unsigned CLK_DIV = 2;
  localparam int unsigned CS_IDLE = 4;
  localparam int unsigned AW      = 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_cmd;
  logic [AW-1:0] req_addr;
  logic [7:0]    req_wdata;
  logic          rsp_valid;
  logic [7:0]    rsp_rdata;
  logic          busy;
  logic          spi_cs;
  logic          spi_sck;
  logic          spi_mosi;
  logic          spi_miso = 1'b0;

  int total = 0;
  int bad   = 0;

  spi_fram_master #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_cmd   (req_cmd),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .spi_cs    (spi_cs),
    .spi_sck   (spi_sck),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural FRAM slave ----------------
  logic [7:0]  emem [int];
  bit          wel = 1'b0;
  bit          in_frame = 1'b0;
  int          nb = 0;
  logic [39:0] sh = '0;
  bit          out_on = 1'b0;
  int          out_start = 0;
  logic [7:0]  out_byte = 8'h00;
  int          fr_bits_q [$];
  logic [39:0] fr_data_q [$];

  always @(negedge spi_cs) begin
    in_frame = 1'b1;
    nb = 0;
    sh = '0;
    out_on = 1'b0;
    spi_miso = 1'b0;
  end

  always @(posedge spi_sck) begin
    if (in_frame && spi_cs == 1'b0) begin
      sh = {sh[38:0], spi_mosi};
      nb++;
      if (nb == 8 && sh[7:0] == 8'h05) begin
        out_on = 1'b1; out_start = 8; out_byte = {6'b0, wel, 1'b0};
      end
      if (nb == 32 && sh[31:24] == 8'h03) begin
        out_on = 1'b1; out_start = 32;
        out_byte = emem.exists(int'(sh[23:0] & 24'h3FFFF)) ? emem[int'(sh[23:0] & 24'h3FFFF)] : 8'h00;
      end
    end
  end

  always @(negedge spi_sck) begin
    if (in_frame) begin
      if (out_on && nb >= out_start && nb < out_start + 8)
        spi_miso = out_byte[7 - (nb - out_start)];
      else
        spi_miso = 1'b0;
    end
  end

  always @(posedge spi_cs) begin
    if (in_frame) begin
      in_frame = 1'b0;
      fr_bits_q.push_back(nb);
      fr_data_q.push_back((nb > 0 && nb <= 40) ? (sh << (40 - nb)) : sh);
      if (nb == 8 && sh[7:0] == 8'h06) wel = 1'b1;
      if (nb == 8 && sh[7:0] == 8'h04) wel = 1'b0;
      if (nb == 40 && sh[39:32] == 8'h02 && wel) begin
        emem[int'(sh[31:8] & 24'h3FFFF)] = sh[7:0];
        wel = 1'b0;
      end
      spi_miso = 1'b0;
    end
  end

  // ---------------- CS timing / response monitor ----------------
  int   len_q [$];
  int   lo_cnt = 0;
  int   hi_cnt = 0;
  bit   first_fr = 1'b1;
  logic prev_cs = 1'b1;
  int   rsp_count = 0;

  always @(negedge clk) begin
    if (rst) begin
      lo_cnt = 0; hi_cnt = 0; first_fr = 1'b1; prev_cs = 1'b1;
    end else begin
      if (spi_cs == 1'b0) begin
        if (prev_cs) begin
          if (!first_fr) chk("cs_gap_min", 64'(hi_cnt >= int'(CS_IDLE)), 64'd1);
          first_fr = 1'b0;
          lo_cnt = 0;
        end
        lo_cnt++;
      end else begin
        if (!prev_cs) begin
          len_q.push_back(lo_cnt);
          hi_cnt = 0;
        end
        hi_cnt++;
      end
      if (rsp_valid) begin
        rsp_count++;
        chk("rsp_at_cs_rise", 64'(!prev_cs && spi_cs), 64'd1);
      end
      prev_cs = spi_cs;
    end
  end

  // ---------------- transaction-level reference model ----------------
  logic [7:0] ref_mem [int];
  bit         ref_wel = 1'b0;

  task automatic ref_step(input logic [1:0] cmd, input logic [23:0] a, input logic [7:0] wd,
                          output logic [7:0] exp);
    int k;
    k = int'(a & 24'h3FFFF);
    exp = 8'h00;
    case (cmd)
      2'b00: ref_wel = 1'b1;
      2'b01: begin
`ifdef SPI_FRAM_AUTO_WREN_EN
        ref_wel = 1'b1;
`endif
        if (ref_wel) begin ref_mem[k] = wd; ref_wel = 1'b0; end
      end
      2'b10: exp = ref_mem.exists(k) ? ref_mem[k] : 8'h00;
      default: exp = ref_wel ? 8'h02 : 8'h00;
    endcase
  endtask

  task automatic exp_frame(input logic [1:0] cmd, input logic [23:0] a, input logic [7:0] wd,
                           output int bits, output logic [39:0] data);
    case (cmd)
      2'b00:   begin bits = 8;  data = {8'h06, 32'h0}; end
      2'b11:   begin bits = 16; data = {8'h05, 32'h0}; end
      2'b10:   begin bits = 40; data = {8'h03, a, 8'h00}; end
      default: begin bits = 40; data = {8'h02, a, wd}; end
    endcase
  endtask

  task automatic check_frame(input logic [1:0] cmd, input logic [23:0] a, input logic [7:0] wd);
    int eb; logic [39:0] ed; int gb; logic [39:0] gd; int gl;
    exp_frame(cmd, a, wd, eb, ed);
    if (fr_bits_q.size() == 0 || len_q.size() == 0) begin
      chk("frame_missing", 64'd0, 64'd1);
    end else begin
      gb = fr_bits_q.pop_front();
      gd = fr_data_q.pop_front();
      gl = len_q.pop_front();
      chk("frame_bits", 64'(gb), 64'(eb));
      chk("frame_mosi", 64'(gd), 64'(ed));
      chk("cs_low_len", 64'(gl), 64'(CLK_DIV * (2 * eb + 2)));
    end
  endtask

  task automatic do_req(input logic [1:0] cmd, input logic [23:0] a, input logic [7:0] wd,
                        output logic [7:0] rd);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_cmd = cmd; req_addr = AW'(a); req_wdata = wd;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    chk("accept_wait", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("ready_drop", 64'(req_ready), 64'd0);
    chk("busy_rise", 64'(busy), 64'd1);
    n = 0;
    while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
    chk("rsp_wait", 64'(rsp_valid), 64'd1);
    rd = rsp_rdata;
    @(negedge clk);
    chk("rsp_one_cycle", 64'(rsp_valid), 64'd0);
    chk("rdata_hold", 64'(rsp_rdata), 64'(rd));
  endtask

  task automatic run_req(input logic [1:0] cmd, input logic [23:0] a, input logic [7:0] wd);
    logic [7:0] exp, got;
    ref_step(cmd, a, wd, exp);
    do_req(cmd, a, wd, got);
    chk("rsp_rdata", 64'(got), 64'(exp));
`ifdef SPI_FRAM_AUTO_WREN_EN
    if (cmd == 2'b01) check_frame(2'b00, a, wd);
`endif
    check_frame(cmd, a, wd);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0]  r1, r2, e;
    logic [23:0] pool [5];
    int          n, rc0;
    logic [1:0]  c;
    logic [23:0] a;

    rst = 1'b1; req_valid = 1'b0; req_cmd = 2'b00; req_addr = '0; req_wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs", 64'(spi_cs), 64'd1);
    chk("rst_sck", 64'(spi_sck), 64'd0);
    chk("rst_mosi", 64'(spi_mosi), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;

    // Directed: WREN, WRITE, READ back
    run_req(2'b00, 24'h0, 8'h00);
    run_req(2'b01, 24'h021234, 8'hA5);
    chk("emu_mem_21234", 64'(emem.exists(32'h21234) ? emem[32'h21234] : 8'h00), 64'hA5);
    run_req(2'b10, 24'h021234, 8'h00);

    // Status: WEL set by WREN, cleared by a bench-side WRDI
    run_req(2'b00, 24'h0, 8'h00);
    run_req(2'b11, 24'h0, 8'h00);
    wel = 1'b0; ref_wel = 1'b0;
    run_req(2'b11, 24'h0, 8'h00);

    // Auto-WREN style write: two frames in that build, dropped write otherwise
    run_req(2'b01, 24'h000010, 8'h3C);
    run_req(2'b10, 24'h000010, 8'h00);

    // Back-to-back READs with req_valid held high
    ref_step(2'b10, 24'h021234, 8'h00, e);
    @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b10; req_addr = AW'(24'h021234); req_wdata = 8'h00;
    n = 0;
    while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
    chk("b2b_rsp1", 64'(rsp_valid), 64'd1);
    r1 = rsp_rdata;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("b2b_ready_back", 64'(req_ready), 64'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_ready_drop", 64'(req_ready), 64'd0);
    n = 0;
    while (!rsp_valid && n < 5000) begin @(negedge clk); n++; end
    chk("b2b_rsp2", 64'(rsp_valid), 64'd1);
    r2 = rsp_rdata;
    @(negedge clk);
    chk("b2b_rdata1", 64'(r1), 64'(e));
    chk("b2b_rdata2", 64'(r2), 64'(e));
    check_frame(2'b10, 24'h021234, 8'h00);
    check_frame(2'b10, 24'h021234, 8'h00);

    // Reset in the middle of a READ, at bit 20
    @(negedge clk);
    while (!req_ready) @(negedge clk);
    req_valid = 1'b1; req_cmd = 2'b10; req_addr = AW'(24'h021234);
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (nb < 20 && n < 2000) begin @(negedge clk); n++; end
    chk("abort_reached_bit20", 64'(nb), 64'd20);
    rc0 = rsp_count;
    #1 rst = 1'b1;
    #1;
    chk("abort_cs", 64'(spi_cs), 64'd1);
    chk("abort_sck", 64'(spi_sck), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_ready", 64'(req_ready), 64'd1);
    chk("abort_no_rsp", 64'(rsp_count), 64'(rc0));
    fr_bits_q.delete(); fr_data_q.delete(); len_q.delete();

    // Randomized traffic against the reference model
    pool[0] = 24'h021234; pool[1] = 24'h000010; pool[2] = 24'h03FFFF;
    pool[3] = 24'h000000; pool[4] = 24'h012345;
    for (int i = 0; i < 30; i++) begin
      c = 2'($urandom_range(0, 3));
      a = ($urandom_range(0, 4) == 4) ? 24'($urandom_range(0, 32'h3FFFF)) : pool[$urandom_range(0, 4)];
      run_req(c, a, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
